// File: rtl/de2_115_qsys_cpu_oci_dct_packer.sv
// Trace atom packer: gathers 2-bit compressed trace atoms into 30-bit words of
// up to SLOTS atoms and hands them downstream through a one-entry valid/ready register.
module de2_115_qsys_cpu_oci_dct_packer #(
    parameter int SLOTS = 15,
    parameter int OVF_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trc_on,
    input  logic               atm_valid,
    input  logic [1:0]         atm_code,
    input  logic               flush,
    output logic [2*SLOTS-1:0] dct_buffer,
    output logic [3:0]         dct_count,
    output logic               pkt_valid,
    output logic [2*SLOTS-1:0] pkt_data,
    output logic [3:0]         pkt_count,
    input  logic               pkt_ready,
    output logic               overflow,
    output logic [OVF_W-1:0]   ovf_count
);

    localparam int WORD_W = 2 * SLOTS;
    localparam logic [3:0] FULL_COUNT = 4'(SLOTS);

    logic              trc_q;
    logic              flush_pend;
    logic              out_free;
    logic              full;
    logic              xfer;
    logic              atm_req;
    logic              accept;
    logic              drop;
    logic              flush_set;
    logic              flush_clr;
    logic              flush_pend_next;
    logic [WORD_W-1:0] buffer_next;
    logic [3:0]        count_next;

    assign out_free  = !pkt_valid || pkt_ready;
    assign full      = (dct_count == FULL_COUNT);
    assign xfer      = (full || (flush_pend && dct_count != 4'd0)) && out_free;
    assign atm_req   = trc_on && atm_valid;
    // A transfer frees the buffer in the same cycle, so a full buffer still accepts.
    assign accept    = atm_req && (!full || xfer);
    assign drop      = atm_req && full && !xfer;
    assign flush_set = flush || (trc_q && !trc_on);
    assign flush_clr = xfer || (dct_count == 4'd0 && !accept);

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        buffer_next = dct_buffer;
        count_next  = dct_count;
        if (xfer) begin
            buffer_next = '0;
            count_next  = 4'd0;
        end
        if (accept) begin
            buffer_next[{count_next, 1'b0} +: 2] = atm_code;
            count_next = count_next + 4'd1;
        end
    end

    // A new flush only stays pending if something is left to cover after this edge.
    always_comb begin
        flush_pend_next = flush_pend && !flush_clr;
        if (flush_set) begin
            flush_pend_next = (count_next != 4'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= 4'd0;
            flush_pend <= 1'b0;
            trc_q      <= 1'b0;
        end else begin
            dct_buffer <= buffer_next;
            dct_count  <= count_next;
            flush_pend <= flush_pend_next;
            trc_q      <= trc_on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_count <= 4'd0;
        end else if (xfer) begin
            pkt_valid <= 1'b1;
            pkt_data  <= dct_buffer;
            pkt_count <= dct_count;
        end else if (pkt_valid && pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_count != '1) begin
                ovf_count <= ovf_count + OVF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_de2_115_qsys_cpu_oci_dct_packer.sv
// Directed bench for the trace atom packer: fill, streaming, backpressure with
// drops, flushes, trace-off edge and asynchronous reset, all hand-computed.
module tb_de2_115_qsys_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trc_on;
    logic        atm_valid;
    logic [1:0]  atm_code;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [29:0] pkt_data;
    logic [3:0]  pkt_count;
    logic        pkt_ready;
    logic        overflow;
    logic [7:0]  ovf_count;

    int errors = 0;
    int checks = 0;
    int words;

    de2_115_qsys_cpu_oci_dct_packer #(.SLOTS(15), .OVF_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .trc_on     (trc_on),
        .atm_valid  (atm_valid),
        .atm_code   (atm_code),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_count  (pkt_count),
        .pkt_ready  (pkt_ready),
        .overflow   (overflow),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        atm_valid = 1'b1;
        atm_code  = c;
        step();
    endtask

    task automatic idle();
        atm_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; trc_on = 1'b0; atm_valid = 1'b0; atm_code = 2'd0;
        flush = 1'b0; pkt_ready = 1'b1;
        step(); step();
        check("rst_count", 32'(dct_count), 32'd0);
        check("rst_buffer", 32'(dct_buffer), 32'd0);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_ovf", 32'(ovf_count), 32'd0);
        reset = 1'b0; trc_on = 1'b1;

        // Fill and emit: codes 1,2,3,0,... pack to 0x39 per four slots.
        for (int i = 0; i < 15; i++) send(2'((i + 1) % 4));
        check("fill_count", 32'(dct_count), 32'd15);
        check("fill_buffer", 32'(dct_buffer), 32'h39393939);
        check("fill_valid_early", 32'(pkt_valid), 32'd0);
        idle();
        check("emit_valid", 32'(pkt_valid), 32'd1);
        check("emit_count", 32'(pkt_count), 32'd15);
        check("emit_data", 32'(pkt_data), 32'h39393939);
        check("emit_dct_count", 32'(dct_count), 32'd0);
        check("emit_buffer", 32'(dct_buffer), 32'd0);
        idle();
        check("emit_drained", 32'(pkt_valid), 32'd0);

        // Continuous stream of 45 atoms: three full words, nothing lost.
        words = 0;
        for (int i = 0; i < 47; i++) begin
            if (i < 45) send(2'(i % 4));
            else idle();
            if (pkt_valid) begin
                words++;
                check("stream_pkt_count", 32'(pkt_count), 32'd15);
            end
        end
        check("stream_words", 32'(words), 32'd3);
        check("stream_overflow", 32'(overflow), 32'd0);
        check("stream_ovf_count", 32'(ovf_count), 32'd0);
        check("stream_dct_count", 32'(dct_count), 32'd0);

        // Backpressure: word 1 all code 1, word 2 all code 2, last 5 atoms dropped.
        pkt_ready = 1'b0;
        for (int i = 0; i < 35; i++) begin
            send(i < 15 ? 2'd1 : 2'd2);
            if (i == 19) begin
                check("bp_hold_valid", 32'(pkt_valid), 32'd1);
                check("bp_hold_data", 32'(pkt_data), 32'h15555555);
            end
        end
        check("bp_stable_data", 32'(pkt_data), 32'h15555555);
        check("bp_stable_count", 32'(pkt_count), 32'd15);
        check("bp_dct_count", 32'(dct_count), 32'd15);
        check("bp_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
        check("bp_ovf_count", 32'(ovf_count), 32'd5);
        check("bp_overflow", 32'(overflow), 32'd1);
        pkt_ready = 1'b1;
        idle();
        check("bp_word2_valid", 32'(pkt_valid), 32'd1);
        check("bp_word2_data", 32'(pkt_data), 32'h2AAAAAAA);
        check("bp_word2_dct_count", 32'(dct_count), 32'd0);
        idle();
        check("bp_drained", 32'(pkt_valid), 32'd0);

        // Flush a partial word: codes 3,1,3,2 pack to 0xB7.
        send(2'd3); send(2'd1); send(2'd3); send(2'd2);
        atm_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_not_yet", 32'(pkt_valid), 32'd0);
        step();
        check("flush_valid", 32'(pkt_valid), 32'd1);
        check("flush_count", 32'(pkt_count), 32'd4);
        check("flush_data", 32'(pkt_data), 32'h000000B7);
        idle();

        // Atom together with flush is covered by that flush.
        send(2'd1); send(2'd1); send(2'd1); send(2'd1);
        flush = 1'b1;
        send(2'd2);
        flush = 1'b0;
        idle();
        check("flush_atom_count", 32'(pkt_count), 32'd5);
        check("flush_atom_data", 32'(pkt_data), 32'h00000255);
        idle();

        // Trace-off edge flushes; atoms while off are ignored.
        for (int i = 0; i < 6; i++) send(2'd3);
        trc_on = 1'b0;
        send(2'd1);
        check("trcoff_count_held", 32'(dct_count), 32'd6);
        send(2'd1);
        check("trcoff_valid", 32'(pkt_valid), 32'd1);
        check("trcoff_pkt_count", 32'(pkt_count), 32'd6);
        check("trcoff_data", 32'(pkt_data), 32'h00000FFF);
        send(2'd1);
        check("trcoff_ignored", 32'(dct_count), 32'd0);
        idle();
        trc_on = 1'b1;

        // Reset mid-operation with a held word and 9 atoms buffered.
        pkt_ready = 1'b0;
        for (int i = 0; i < 24; i++) send(2'd1);
        atm_valid = 1'b0;
        check("pre_rst_count", 32'(dct_count), 32'd9);
        check("pre_rst_valid", 32'(pkt_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_count", 32'(dct_count), 32'd0);
        check("arst_buffer", 32'(dct_buffer), 32'd0);
        check("arst_valid", 32'(pkt_valid), 32'd0);
        check("arst_data", 32'(pkt_data), 32'd0);
        check("arst_pkt_count", 32'(pkt_count), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_ovf_count", 32'(ovf_count), 32'd0);
        #1 reset = 1'b0;
        send(2'd2);
        check("post_rst_count", 32'(dct_count), 32'd1);
        check("post_rst_slot0", 32'(dct_buffer), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
